// File: rtl/phase_ramp_gen_v4_pkg.sv
// rtl/phase_ramp_gen_v4_pkg.sv - shared widths and reset constant for the phase ramp generator
package phase_ramp_gen_v4_pkg;

  localparam int          OUTPUT_BIT_DEF = 32;
  localparam int          STEP_W         = 32;
  localparam int          GAIN_W         = 4;
  localparam int unsigned RST_VAL        = 0;

endpackage

// File: rtl/phase_ramp_gen_v4_ramp_step_shifter.sv
// rtl/phase_ramp_gen_v4_ramp_step_shifter.sv - combinational arithmetic right shift of the ladder step
module ramp_step_shifter
  import phase_ramp_gen_v4_pkg::*;
#(
  parameter int OUTPUT_BIT = OUTPUT_BIT_DEF
) (
  input  logic [STEP_W-1:0]     i_step,
  input  logic [GAIN_W-1:0]     i_shift,
  output logic [OUTPUT_BIT-1:0] o_step
);

  logic signed [STEP_W-1:0] shifted;

  assign shifted = $signed(i_step) >>> i_shift;

  // Resize to the accumulator width, keeping the sign when widening.
  generate
    if (OUTPUT_BIT > STEP_W) begin : g_widen
      assign o_step = {{(OUTPUT_BIT-STEP_W){shifted[STEP_W-1]}}, shifted};
    end else if (OUTPUT_BIT == STEP_W) begin : g_same
      assign o_step = shifted;
    end else begin : g_narrow
      assign o_step = shifted[OUTPUT_BIT-1:0];
    end
  endgenerate

endmodule

// File: rtl/phase_ramp_gen_v4.sv
// rtl/phase_ramp_gen_v4.sv - triggered phase ladder accumulator plus modulation; PHASE_RAMP_GAIN_LATCH_EN latches gain on trigger
module phase_ramp_gen_v4
  import phase_ramp_gen_v4_pkg::*;
#(
  parameter int OUTPUT_BIT = OUTPUT_BIT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_trig,
  input  logic [STEP_W-1:0]     i_step,
  input  logic [31:0]           i_fb_on,
  input  logic [OUTPUT_BIT-1:0] i_mod,
  input  logic [GAIN_W-1:0]     i_gain_sel,
  output logic [OUTPUT_BIT-1:0] o_ladderWave,
  output logic [OUTPUT_BIT-1:0] o_phaseRamp,
  output logic [GAIN_W-1:0]     o_shift_idx
);

  logic                  trig_q, trig_d;
  logic                  armed_q, armed_d;
  logic [GAIN_W-1:0]     shift_q, shift_d;
  logic [OUTPUT_BIT-1:0] ladder_q, ladder_d;
  logic [OUTPUT_BIT-1:0] phase_q, phase_d;
  logic                  trig_edge;
  logic                  fb_en;
  logic [GAIN_W-1:0]     shift_apply;
  logic [OUTPUT_BIT-1:0] step_eff;

  // armed stays low until i_trig is seen low, so a trigger held across reset release is ignored.
  always_comb begin
    trig_d    = i_trig;
    armed_d   = armed_q | ~i_trig;
    trig_edge = i_trig & ~trig_q & armed_q;
    fb_en     = |i_fb_on;
`ifdef PHASE_RAMP_GAIN_LATCH_EN
    shift_d     = trig_edge ? i_gain_sel : shift_q;
    shift_apply = trig_edge ? i_gain_sel : shift_q;
`else
    shift_d     = i_gain_sel;
    shift_apply = shift_q;
`endif
  end

  ramp_step_shifter #(.OUTPUT_BIT(OUTPUT_BIT)) u_shifter (
    .i_step  (i_step),
    .i_shift (shift_apply),
    .o_step  (step_eff)
  );

  // Wrapping add is intentional: overflow is the 2-pi phase reset.
  always_comb begin
    ladder_d = ladder_q;
    if (!fb_en) begin
      ladder_d = '0;
    end else if (trig_edge) begin
      ladder_d = ladder_q + step_eff;
    end
    phase_d = ladder_q + i_mod;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trig_q   <= 1'b0;
      armed_q  <= 1'b0;
      shift_q  <= GAIN_W'(RST_VAL);
      ladder_q <= OUTPUT_BIT'(RST_VAL);
      phase_q  <= OUTPUT_BIT'(RST_VAL);
    end else begin
      trig_q   <= trig_d;
      armed_q  <= armed_d;
      shift_q  <= shift_d;
      ladder_q <= ladder_d;
      phase_q  <= phase_d;
    end
  end

  assign o_ladderWave = ladder_q;
  assign o_phaseRamp  = phase_q;
  assign o_shift_idx  = shift_q;

endmodule

// File: tb/tb_phase_ramp_gen_v4.sv
// tb/tb_phase_ramp_gen_v4.sv - directed self-checking bench for phase_ramp_gen_v4
module tb_phase_ramp_gen_v4;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic [31:0] step;
  logic [31:0] fb_on;
  logic [31:0] mod;
  logic [3:0]  gain_sel;
  logic [31:0] ladder;
  logic [31:0] phase;
  logic [3:0]  shift_idx;

  int errors = 0;
  int checks = 0;

  phase_ramp_gen_v4 #(.OUTPUT_BIT(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_trig       (trig),
    .i_step       (step),
    .i_fb_on      (fb_on),
    .i_mod        (mod),
    .i_gain_sel   (gain_sel),
    .o_ladderWave (ladder),
    .o_phaseRamp  (phase),
    .o_shift_idx  (shift_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    trig     = 1'b0;
    step     = 32'd0;
    fb_on    = 32'd0;
    mod      = 32'd0;
    gain_sel = 4'd0;
    #2;
    check("rst_ladder", ladder, 32'd0);
    check("rst_phase", phase, 32'd0);
    check("rst_shift", {28'd0, shift_idx}, 32'd0);
    tick();
    tick();

    // Three-step ramp, effective step -50
    rst_n    = 1'b1;
    fb_on    = 32'd1;
    step     = -32'sd100;
    gain_sel = 4'd1;
    tick();
    tick();
    check("shift_follow", {28'd0, shift_idx}, 32'd1);
    check("hold_no_trig", ladder, 32'd0);
    trig = 1'b1; tick();
    check("ramp1", ladder, 32'hFFFF_FFCE);
    trig = 1'b0; tick();
    check("phase1", phase, 32'hFFFF_FFCE);
    trig = 1'b1; tick();
    check("ramp2", ladder, 32'hFFFF_FF9C);
    trig = 1'b0; tick();
    trig = 1'b1; tick();
    check("ramp3", ladder, 32'hFFFF_FF6A);
    trig = 1'b0; tick(); tick();
    check("ramp3_hold", ladder, 32'hFFFF_FF6A);

    // Ladder -50 plus modulation 100
    fb_on = 32'd0; tick();
    check("fb_off_clear", ladder, 32'd0);
    fb_on = 32'd1;
    mod   = 32'd100;
    tick();
    trig = 1'b1; tick();
    check("mod_ladder", ladder, 32'hFFFF_FFCE);
    check("mod_phase_old", phase, 32'd100);
    trig = 1'b0; tick();
    check("mod_phase", phase, 32'd50);

    // fb_on dropped together with a trigger edge
    mod   = 32'd0;
    trig  = 1'b1;
    fb_on = 32'd0;
    tick();
    check("fb_prio", ladder, 32'd0);
    trig     = 1'b0;
    fb_on    = 32'd1;
    step     = 32'h40;
    gain_sel = 4'd2;
    tick();
    tick();
    trig = 1'b1; tick();
    check("fb_restore", ladder, 32'h10);
    trig = 1'b0; tick();

    // Wrap past the positive limit
    fb_on = 32'd0; tick();
    fb_on    = 32'd1;
    step     = 32'h7FFF_FFF0;
    gain_sel = 4'd0;
    tick();
    trig = 1'b1; tick();
    check("wrap_pre", ladder, 32'h7FFF_FFF0);
    trig = 1'b0;
    step = 32'h20;
    tick();
    trig = 1'b1; tick();
    check("wrap", ladder, 32'h8000_0010);
    trig = 1'b0; tick();

    // Long pulse, maximum shift
    fb_on = 32'd0; tick();
    fb_on    = 32'd1;
    step     = -32'sd100;
    gain_sel = 4'd15;
    tick();
    check("shift15", {28'd0, shift_idx}, 32'd15);
    trig = 1'b1; tick();
    check("long_first", ladder, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) tick();
    check("long_held", ladder, 32'hFFFF_FFFF);
    trig = 1'b0; tick();
    check("long_release", ladder, 32'hFFFF_FFFF);

    // Reset mid-ramp with a trigger high across release
    mod = 32'd7; tick();
    check("pre_rst_phase", phase, 32'd6);
    rst_n = 1'b0;
    trig  = 1'b1;
    #1;
    check("async_ladder", ladder, 32'd0);
    check("async_phase", phase, 32'd0);
    check("async_shift", {28'd0, shift_idx}, 32'd0);
    mod = 32'd0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("no_stale_trig", ladder, 32'd0);
    trig = 1'b0; tick();
    check("still_zero", ladder, 32'd0);
    trig = 1'b1; tick();
    check("fresh_trig", ladder, 32'hFFFF_FFFF);
    trig = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_ramp_gen_v4.md
PHASE_RAMP_GEN_V4 -- requirements
Module: phase_ramp_gen_v4

Interface
REQ-001 SHALL have parameter OUTPUT_BIT, default 32: width of i_mod, o_ladderWave and o_phaseRamp.
REQ-002 SHALL have one clock and an asynchronous active-low reset, as listed below:
- i_clk  input  1  sole clock; all state updates on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
REQ-003 i_trig  input  1  step trigger from modulation_gen_v4 (o_stepTrig); level signal, only its rising edge is significant.
REQ-004 i_step  input  32  signed two's-complement ladder step.
REQ-005 i_fb_on  input  32  feedback enable; nonzero = on.
REQ-006 i_mod  input  OUTPUT_BIT  modulation word from modulation_gen_v4 (o_mod_out).
REQ-007 i_gain_sel  input  4  arithmetic right-shift amount (0..15) applied to i_step.
REQ-008 o_ladderWave  output  OUTPUT_BIT  registered ladder accumulator.
REQ-009 o_phaseRamp  output  OUTPUT_BIT  registered ladder plus modulation.
REQ-010 o_shift_idx  output  4  shift amount currently applied to the step.

Function
REQ-011 SHALL register i_trig once and detect its rising edge as (i_trig AND NOT previous i_trig).
REQ-012 Effective step SHALL be i_step arithmetic-shifted right by the applied shift, sign-extended or truncated to OUTPUT_BIT.
REQ-013 On a clock with a detected edge and i_fb_on != 0, ladder SHALL become ladder + effective step on that same edge (1-cycle latency after i_trig rises).
REQ-014 Ladder addition SHALL wrap modulo 2^OUTPUT_BIT with no saturation, because the wrap is the 2-pi reset.
REQ-015 Without a detected edge, the ladder SHALL hold its value.
REQ-016 While i_fb_on == 0, the ladder SHALL be cleared to 0 on every clock, and this SHALL take priority over a simultaneous edge.
REQ-017 o_phaseRamp SHALL be registered as ladder + i_mod, modulo 2^OUTPUT_BIT: one cycle after the ladder update, two cycles after i_trig rises.
REQ-018 o_shift_idx SHALL equal the shift used by the most recent ladder update path (see REQ-022/023).
REQ-019 Each i_trig pulse SHALL produce exactly one update, regardless of the pulse width in clocks.

Reset
REQ-020 While i_rst_n is low, the ladder, o_ladderWave, o_phaseRamp, o_shift_idx and the trigger delay register SHALL all be 0, asynchronously.
REQ-021 After reset release, the first update SHALL occur only on a fresh rising edge of i_trig; a trigger that is high at release SHALL NOT count.

Configuration
REQ-022 With PHASE_RAMP_GAIN_LATCH_EN defined, i_gain_sel SHALL be sampled into the shift register only on a detected trigger edge, so the shift stays constant between steps.
REQ-023 Without PHASE_RAMP_GAIN_LATCH_EN, i_gain_sel SHALL be registered every clock; the shift then follows i_gain_sel with 1-cycle delay.

Structure
REQ-024 A shared package SHALL hold OUTPUT_BIT default, the gain-select width (4) and the reset constant 0.
REQ-025 A single sub-module, ramp_step_shifter (combinational arithmetic right shift of the step), is natural; the edge detector and accumulator SHALL stay inline.
REQ-026 modulation_gen_v4 SHALL remain a separate block that drives i_trig and i_mod; it is not part of this module.

Verification
REQ-027 Reset, then fb_on=1, step=-100, gain_sel=1, mod=0, three i_trig pulses -> ladder -50, -100, -150 (0xFFFFFF6A), each value one clock after its trigger rises.
REQ-028 Ladder=0x7FFFFFF0, step=0x20, gain_sel=0, one trigger -> ladder 0x80000010 (wrap, no saturation).
REQ-029 Ladder=-50, i_mod=100 held -> o_phaseRamp=50 two clocks after the trigger edge.
REQ-030 fb_on dropped to 0 during a trigger -> ladder 0 on the next clock; restoring fb_on=1 plus one trigger -> ladder equals the effective step.
REQ-031 i_trig held high for 10 clocks -> exactly one update; with gain_sel=15 and step=-100, effective step is -1.
REQ-032 i_rst_n asserted mid-ramp -> all outputs 0 immediately; after release, no update until the next i_trig rising edge.
